// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding / load-use hazard unit.
//   FWD_*    : encodings of the 2-bit EX operand-forwarding mux select
//   stage_t  : one pipeline shadow-stage record
//   fwd_match: true when a stage will write back the given source register
package fwd_pkg;

  localparam int unsigned RegAddrW = 5;
  localparam int unsigned SelW     = 2;

  localparam logic [SelW-1:0] FWD_REG   = 2'b00;  // register-file operand
  localparam logic [SelW-1:0] FWD_EXMEM = 2'b01;  // EX/MEM ALU result
  localparam logic [SelW-1:0] FWD_MEMWB = 2'b10;  // MEM/WB write-back data
  localparam logic [SelW-1:0] FWD_RSVD  = 2'b11;  // reserved, never driven

  typedef struct packed {
    logic                valid;
    logic [RegAddrW-1:0] rs1;
    logic [RegAddrW-1:0] rs2;
    logic [RegAddrW-1:0] rd;
    logic                reg_write;
    logic                mem_read;
  } stage_t;

  // x0 is hard-wired zero, so a write to it must never be forwarded.
  function automatic logic fwd_match(input stage_t s, input logic [RegAddrW-1:0] src);
    return s.valid && s.reg_write && (s.rd != '0) && (s.rd == src);
  endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One shadow pipeline stage (ID/EX, EX/MEM or MEM/WB record).
// Ports:
//   clk_i    : rising-edge clock
//   rst_i    : asynchronous active-high reset, clears every field
//   bubble_i : load a bubble (valid, reg_write, mem_read forced low)
//   d_i      : record from the previous stage
//   q_o      : registered record
module hazard_stage_reg
  import fwd_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   bubble_i,
  input  stage_t d_i,
  output stage_t q_o
);

  stage_t stage_d, stage_q;

  always_comb begin
    stage_d = d_i;
    if (bubble_i) begin
      stage_d.valid     = 1'b0;
      stage_d.reg_write = 1'b0;
      stage_d.mem_read  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q_o = stage_q;

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding select generation and load-use stall detection.
// Shadows decode through ID/EX, EX/MEM and MEM/WB and drives the selects of the
// two EX-stage 4:1 operand muxes. A load-use hazard requests a one-cycle stall and
// inserts a bubble into the ID/EX shadow; flush also bubbles ID/EX and masks stall.
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   id_valid, id_rs1, id_rs2,
//   id_rd, id_reg_write,
//   id_mem_read               : decode-slot instruction
//   flush                     : branch taken, kill the decode slot
//   stall                     : hold PC and IF/ID (combinational)
//   fwd_a_sel, fwd_b_sel      : operand mux selects (from flops only)
//   stall_cnt                 : stall-cycle counter, present only with FWD_STALL_CNT_EN
// Build option: define FWD_STALL_CNT_EN to add the stall_cnt output.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = RegAddrW,
  parameter int unsigned SEL_W      = SelW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  flush,
  output logic                  stall,
  output logic [SEL_W-1:0]      fwd_a_sel,
  output logic [SEL_W-1:0]      fwd_b_sel
`ifdef FWD_STALL_CNT_EN
  ,
  output logic [31:0]           stall_cnt
`endif
);

  stage_t id_rec, idex_q, exmem_q, memwb_q;
  logic   idex_bubble;

  always_comb begin
    id_rec           = '0;
    id_rec.valid     = id_valid;
    id_rec.rs1       = id_rs1;
    id_rec.rs2       = id_rs2;
    id_rec.rd        = id_rd;
    id_rec.reg_write = id_reg_write;
    id_rec.mem_read  = id_mem_read;
  end

  assign idex_bubble = stall | flush;

  hazard_stage_reg u_idex (
    .clk_i    (clk),
    .rst_i    (rst),
    .bubble_i (idex_bubble),
    .d_i      (id_rec),
    .q_o      (idex_q)
  );

  hazard_stage_reg u_exmem (
    .clk_i    (clk),
    .rst_i    (rst),
    .bubble_i (1'b0),
    .d_i      (idex_q),
    .q_o      (exmem_q)
  );

  hazard_stage_reg u_memwb (
    .clk_i    (clk),
    .rst_i    (rst),
    .bubble_i (1'b0),
    .d_i      (exmem_q),
    .q_o      (memwb_q)
  );

  // Load in EX whose result the decode slot needs; flush kills the consumer anyway.
  assign stall = idex_q.valid && idex_q.mem_read && (idex_q.rd != '0) &&
                 ((idex_q.rd == id_rs1) || (idex_q.rd == id_rs2)) &&
                 id_valid && !flush;

  // EX/MEM is the younger producer, so it wins over MEM/WB.
  always_comb begin
    fwd_a_sel = FWD_REG;
    fwd_b_sel = FWD_REG;
    if (idex_q.valid) begin
      if (fwd_match(exmem_q, idex_q.rs1)) begin
        fwd_a_sel = FWD_EXMEM;
      end else if (fwd_match(memwb_q, idex_q.rs1)) begin
        fwd_a_sel = FWD_MEMWB;
      end
      if (fwd_match(exmem_q, idex_q.rs2)) begin
        fwd_b_sel = FWD_EXMEM;
      end else if (fwd_match(memwb_q, idex_q.rs2)) begin
        fwd_b_sel = FWD_MEMWB;
      end
    end
  end

  // Source fields of the later stages are tracked but not consumed here.
  logic unused_stage_bits;
  assign unused_stage_bits = ^{exmem_q.rs1, exmem_q.rs2, exmem_q.mem_read,
                               memwb_q.rs1, memwb_q.rs2, memwb_q.mem_read};

`ifdef FWD_STALL_CNT_EN
  logic [31:0] stall_cnt_d, stall_cnt_q;

  // Wraps naturally from all-ones to zero.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: each step drives one decode slot, checks the
// combinational stall, queues the selects expected once that slot reaches EX, and
// pops/compares them one clock later.
module tb_fwd_hazard_unit;
  import fwd_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_reg_write, id_mem_read, flush;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       stall;
  logic [1:0] fwd_a_sel, fwd_b_sel;
`ifdef FWD_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  fwd_hazard_unit #(
    .REG_ADDR_W (5),
    .SEL_W      (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .flush        (flush),
    .stall        (stall),
    .fwd_a_sel    (fwd_a_sel),
    .fwd_b_sel    (fwd_b_sel)
`ifdef FWD_STALL_CNT_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string      tag;
    logic [1:0] a;
    logic [1:0] b;
  } exp_t;

  exp_t sb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic rw, input logic mr,
                       input logic fl);
    id_valid     = v;
    id_rs1       = rs1;
    id_rs2       = rs2;
    id_rd        = rd;
    id_reg_write = rw;
    id_mem_read  = mr;
    flush        = fl;
  endtask

  // One decode cycle: stall checked before the edge, selects of this slot after it.
  task automatic issue(input string tag, input logic v, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic rw,
                       input logic mr, input logic fl, input logic exp_stall,
                       input logic [1:0] exp_a, input logic [1:0] exp_b);
    exp_t e;
    @(negedge clk);
    drive(v, rs1, rs2, rd, rw, mr, fl);
    #1;
    chk({tag, ".stall"}, 32'(stall), 32'(exp_stall));
    e.tag = tag;
    e.a   = exp_a;
    e.b   = exp_b;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk({e.tag, ".a"}, 32'(fwd_a_sel), 32'(e.a));
    chk({e.tag, ".b"}, 32'(fwd_b_sel), 32'(e.b));
    if (fwd_a_sel == FWD_RSVD || fwd_b_sel == FWD_RSVD) begin
      chk({e.tag, ".rsvd"}, 32'({fwd_a_sel, fwd_b_sel}), 32'({e.a, e.b}));
    end
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) begin
      issue("nop", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, FWD_REG, FWD_REG);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("reset.stall", 32'(stall), 32'd0);
    chk("reset.a", 32'(fwd_a_sel), 32'(FWD_REG));
    chk("reset.b", 32'(fwd_b_sel), 32'(FWD_REG));
`ifdef FWD_STALL_CNT_EN
    chk("reset.cnt", stall_cnt, 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // add x5,x1,x2 ; add x6,x5,x1 -> EX/MEM forward on A
    issue("t1.add5", 1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, FWD_REG, FWD_REG);
    issue("t1.add6", 1'b1, 5'd5, 5'd1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, FWD_EXMEM, FWD_REG);
    nops(3);

    // add x5 ; nop ; sub x7,x1,x5 -> MEM/WB forward on B
    issue("t2.add5", 1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, FWD_REG, FWD_REG);
    nops(1);
    issue("t2.sub7", 1'b1, 5'd1, 5'd5, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, FWD_REG, FWD_MEMWB);
    nops(3);

    // lw x8 ; add x9,x8,x8 -> one stall, bubble forwards nothing, then MEM/WB on both
    issue("t3.lw8", 1'b1, 5'd1, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, FWD_REG, FWD_REG);
    issue("t3.use_stall", 1'b1, 5'd8, 5'd8, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, FWD_REG, FWD_REG);
    issue("t3.use_go", 1'b1, 5'd8, 5'd8, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, FWD_MEMWB, FWD_MEMWB);
    nops(3);

    // x0 never forwarded; two producers of x4 -> EX/MEM has priority
    issue("t4.add0", 1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, FWD_REG, FWD_REG);
    issue("t4.add3", 1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, FWD_REG, FWD_REG);
    nops(3);
    issue("t4.add4a", 1'b1, 5'd1, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, FWD_REG, FWD_REG);
    issue("t4.add4b", 1'b1, 5'd1, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, FWD_REG, FWD_REG);
    issue("t4.use4", 1'b1, 5'd4, 5'd4, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, FWD_EXMEM, FWD_EXMEM);
    nops(3);

    // lw x8 ; flushed add x9,x8,x8 -> no stall; add x10,x9,x8 sees no x9 forward
    issue("t5.lw8", 1'b1, 5'd1, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, FWD_REG, FWD_REG);
    issue("t5.flush", 1'b1, 5'd8, 5'd8, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, FWD_REG, FWD_REG);
    issue("t5.add10", 1'b1, 5'd9, 5'd8, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, FWD_REG, FWD_MEMWB);
    nops(3);

    // Reset asserted in the middle of a stall cycle
    issue("t6.lw8", 1'b1, 5'd1, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, FWD_REG, FWD_REG);
    @(negedge clk);
    drive(1'b1, 5'd8, 5'd8, 5'd9, 1'b1, 1'b0, 1'b0);
    #1;
    chk("t6.pre_rst_stall", 32'(stall), 32'd1);
    rst = 1'b1;
    #1;
    chk("t6.rst_stall", 32'(stall), 32'd0);
    chk("t6.rst_a", 32'(fwd_a_sel), 32'(FWD_REG));
    chk("t6.rst_b", 32'(fwd_b_sel), 32'(FWD_REG));
`ifdef FWD_STALL_CNT_EN
    chk("t6.rst_cnt", stall_cnt, 32'd0);
`endif
    @(negedge clk);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Three load-use stalls, including back-to-back loads
    issue("t7.lw8", 1'b1, 5'd1, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, FWD_REG, FWD_REG);
    issue("t7.use8_s", 1'b1, 5'd8, 5'd8, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, FWD_REG, FWD_REG);
    issue("t7.use8_g", 1'b1, 5'd8, 5'd8, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, FWD_MEMWB, FWD_MEMWB);
    issue("t7.lw8b", 1'b1, 5'd1, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, FWD_REG, FWD_REG);
    issue("t7.lw9_s", 1'b1, 5'd8, 5'd0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1, FWD_REG, FWD_REG);
    issue("t7.lw9_g", 1'b1, 5'd8, 5'd0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, FWD_MEMWB, FWD_REG);
    issue("t7.add10_s", 1'b1, 5'd9, 5'd0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b1, FWD_REG, FWD_REG);
    issue("t7.add10_g", 1'b1, 5'd9, 5'd0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, FWD_MEMWB, FWD_REG);
`ifdef FWD_STALL_CNT_EN
    chk("t7.cnt", stall_cnt, 32'd3);
`endif
    nops(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
